// File: rtl/meas_result_buf.sv
// Measurement result buffer.
// Each done strobe is timestamped and queued into a first-word-fall-through
// FIFO that has a registered output stage. Alongside the FIFO the block keeps
// saturating shot/decision statistics and a sticky overflow indication.
module meas_result_buf #(
    parameter int AW = 4,
    parameter int DW = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 done,
    input  logic                 resultx,
    input  logic                 resulty,
    input  logic signed [DW-1:0] xacc,
    input  logic signed [DW-1:0] yacc,
    input  logic                 tclear,
    input  logic                 sclear,
    input  logic                 rd_ready,
    output logic                 rd_valid,
    output logic [2*DW+33:0]     rd_data,
    output logic [AW:0]          level,
    output logic                 ovf,
    output logic [15:0]          drop_cnt,
    output logic [15:0]          nshots,
    output logic [15:0]          nx1,
    output logic [15:0]          ny1
);

    localparam int EW    = 2 * DW + 34;
    localparam int DEPTH = 1 << AW;

    logic [EW-1:0] mem_q [DEPTH];

    logic [31:0]   ts_q,       ts_d;
    logic [AW:0]   wr_ptr_q,   wr_ptr_d;
    logic [AW:0]   rd_ptr_q,   rd_ptr_d;
    logic          rd_valid_q, rd_valid_d;
    logic [EW-1:0] rd_data_q,  rd_data_d;
    logic          ovf_q,      ovf_d;
    logic [15:0]   drop_cnt_q, drop_cnt_d;
    logic [15:0]   nshots_q,   nshots_d;
    logic [15:0]   nx1_q,      nx1_d;
    logic [15:0]   ny1_q,      ny1_d;

    logic          full;
    logic          empty;
    logic          pop;
    logic          push;
    logic          drop;
    logic [AW:0]   rd_ptr_inc;
    logic [EW-1:0] entry;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // FIFO status and handshake decode; a pop frees the slot a same-cycle push may use
    always_comb begin
        full       = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
        empty      = (wr_ptr_q == rd_ptr_q);
        pop        = rd_valid_q && rd_ready;
        push       = done && (!full || pop);
        drop       = done && full && !pop;
        rd_ptr_inc = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        entry      = {ts_q, yacc, xacc, resulty, resultx};
    end

    // Next-state for timestamp, pointers, output stage and statistics
    always_comb begin
        ts_d       = tclear ? 32'd0 : ts_q + 32'd1;
        wr_ptr_d   = push ? wr_ptr_q + {{AW{1'b0}}, 1'b1} : wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;

        // The output register mirrors the head slot; the head is only retired
        // from memory on a pop, so level naturally includes the presented entry.
        if (pop) begin
            rd_ptr_d = rd_ptr_inc;
            if (wr_ptr_q != rd_ptr_inc) begin
                rd_valid_d = 1'b1;
                rd_data_d  = mem_q[rd_ptr_inc[AW-1:0]];
            end else begin
                rd_valid_d = 1'b0;
            end
        end else if (!rd_valid_q && !empty) begin
            rd_valid_d = 1'b1;
            rd_data_d  = mem_q[rd_ptr_q[AW-1:0]];
        end

        // Clearing wins over counting a coincident result
        if (sclear) begin
            ovf_d      = 1'b0;
            drop_cnt_d = 16'd0;
            nshots_d   = 16'd0;
            nx1_d      = 16'd0;
            ny1_d      = 16'd0;
        end else begin
            ovf_d      = ovf_q | drop;
            drop_cnt_d = drop ? sat_inc(drop_cnt_q) : drop_cnt_q;
            nshots_d   = done ? sat_inc(nshots_q) : nshots_q;
            nx1_d      = (done && resultx) ? sat_inc(nx1_q) : nx1_q;
            ny1_d      = (done && resulty) ? sat_inc(ny1_q) : ny1_q;
        end
    end

    // Control and statistics registers with asynchronous reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts_q       <= 32'd0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            ovf_q      <= 1'b0;
            drop_cnt_q <= 16'd0;
            nshots_q   <= 16'd0;
            nx1_q      <= 16'd0;
            ny1_q      <= 16'd0;
        end else begin
            ts_q       <= ts_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            ovf_q      <= ovf_d;
            drop_cnt_q <= drop_cnt_d;
            nshots_q   <= nshots_d;
            nx1_q      <= nx1_d;
            ny1_q      <= ny1_d;
        end
    end

    // Entry storage; contents are don't-care until the pointers cover them
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= entry;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign level    = wr_ptr_q - rd_ptr_q;
    assign ovf      = ovf_q;
    assign drop_cnt = drop_cnt_q;
    assign nshots   = nshots_q;
    assign nx1      = nx1_q;
    assign ny1      = ny1_q;

endmodule
